// File: rtl/expr_pkg.sv
// Constants and state encoding shared by the expression transmitter and the
// recognizer that consumes its character stream.
package expr_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;  // "0"
    localparam logic [7:0] CH_ADD  = 8'h2B;  // "+"
    localparam logic [7:0] CH_MUL  = 8'h2A;  // "*"

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_ZERO + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic b);
        return (b == OP_MUL) ? CH_MUL : CH_ADD;
    endfunction

endpackage

// File: rtl/expr_tx_if.sv
// Request and character-stream signals of the expression transmitter; master is
// the transmitter side, slave is the requester/sink side.
interface expr_tx_if #(
    parameter int MAX_TERMS = 8,
    parameter int NW        = $clog2(MAX_TERMS + 1),
    parameter int OPW       = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1
);
    logic                   start;
    logic [NW-1:0]          nterms;
    logic [4*MAX_TERMS-1:0] digits;
    logic [OPW-1:0]         ops;
    logic [7:0]             out;
    logic                   valid;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        input  start, nterms, digits, ops, ready,
        output out, valid, busy, done, err
    );

    modport slave (
        output start, nterms, digits, ops, ready,
        input  out, valid, busy, done, err
    );
endinterface

// File: rtl/expr_req_check.sv
// Combinational validator for a transmit request: operand count in range and
// every operand that will be sent is a legal BCD digit.
module expr_req_check
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int NW        = $clog2(MAX_TERMS + 1)
) (
    input  logic [NW-1:0]          nterms,
    input  logic [4*MAX_TERMS-1:0] digits,
    output logic                   ok
);

    always_comb begin
        ok = 1'b1;
        if (nterms == '0)
            ok = 1'b0;
        if (int'(nterms) > MAX_TERMS)
            ok = 1'b0;
        // Operands at or beyond nterms are never sent, so their contents don't matter.
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((i < int'(nterms)) && (digits[4*i +: 4] > 4'd9))
                ok = 1'b0;
        end
    end

endmodule

// File: rtl/expr_tx.sv
// Serial ASCII expression transmitter: streams "d(op d)*" one character per
// valid/ready transfer from operands and operators latched at start.
module expr_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int NW        = $clog2(MAX_TERMS + 1)
) (
    input  logic      clk,
    input  logic      clr,
    expr_tx_if.master bus
);

    localparam int OPW = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

    state_t                 state, state_nx;
    logic [NW-1:0]          idx, idx_nx, idx_inc;
    logic [NW-1:0]          n_lat;
    logic [4*MAX_TERMS-1:0] dig_lat;
    logic [OPW-1:0]         ops_lat;
    logic [7:0]             out_r, out_nx;
    logic                   valid_r, valid_nx;
    logic                   busy_r, busy_nx;
    logic                   done_r, done_nx;
    logic                   err_r, err_nx;
    logic                   load;
    logic                   req_ok;
    logic                   last;

    expr_req_check #(
        .MAX_TERMS (MAX_TERMS),
        .NW        (NW)
    ) u_check (
        .nterms (bus.nterms),
        .digits (bus.digits),
        .ok     (req_ok)
    );

    function automatic logic [3:0] sel_digit(input logic [4*MAX_TERMS-1:0] v,
                                             input logic [NW-1:0] k);
        sel_digit = 4'h0;
        for (int i = 0; i < MAX_TERMS; i++)
            if (k == NW'(i))
                sel_digit = v[4*i +: 4];
    endfunction

    function automatic logic sel_op(input logic [OPW-1:0] v, input logic [NW-1:0] k);
        sel_op = OP_ADD;
        for (int i = 0; i < OPW; i++)
            if (k == NW'(i))
                sel_op = v[i];
    endfunction

    assign idx_inc = idx + NW'(1);
    assign last    = (idx == n_lat - NW'(1));

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        out_nx   = out_r;
        valid_nx = valid_r;
        busy_nx  = busy_r;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (req_ok) begin
                        load     = 1'b1;
                        idx_nx   = '0;
                        state_nx = DIGIT;
                        // Latches are still loading this edge, so take operand 0 from the port.
                        out_nx   = digit_char(bus.digits[3:0]);
                        valid_nx = 1'b1;
                        busy_nx  = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (bus.ready) begin
                    if (last) begin
                        state_nx = IDLE;
                        out_nx   = 8'h00;
                        valid_nx = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = OP;
                        out_nx   = op_char(sel_op(ops_lat, idx));
                    end
                end
            end
            OP: begin
                if (bus.ready) begin
                    state_nx = DIGIT;
                    idx_nx   = idx_inc;
                    out_nx   = digit_char(sel_digit(dig_lat, idx_inc));
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            idx     <= '0;
            out_r   <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            out_r   <= out_nx;
            valid_r <= valid_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
            err_r   <= err_nx;
        end
    end

    // Request payload registers: only meaningful while busy, so no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            n_lat   <= bus.nterms;
            dig_lat <= bus.digits;
            ops_lat <= bus.ops;
        end
    end

    assign bus.out   = out_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_expr_tx.sv
// Randomized bench for expr_tx: expected character strings are built directly
// from the operand/operator lists and compared transfer by transfer.
module tb_expr_tx;

    localparam int MT = 8;
    localparam int NW = $clog2(MT + 1);

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    expr_tx_if #(.MAX_TERMS(MT)) bus ();

    expr_tx #(.MAX_TERMS(MT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a request is legal if 1<=n<=MT and every sent operand is 0..9.
    function automatic bit req_legal(input int n, input logic [4*MT-1:0] d);
        if (n < 1 || n > MT) return 1'b0;
        for (int i = 0; i < n; i++)
            if (d[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // mode 0: ready high, 1: ready pattern 1,0,0,1,0,0..., 2: random ready
    task automatic send(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o,
                        input int mode, input bit poke_busy);
        logic [7:0] q[$];
        int   k;
        int   cyc;
        logic r;
        for (int i = 0; i < n; i++) begin
            q.push_back(8'd48 + {4'h0, d[4*i +: 4]});
            if (i < n - 1) q.push_back(o[i] ? 8'h2A : 8'h2B);
        end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.nterms = n[NW-1:0];
        bus.digits = d;
        bus.ops    = o;
        bus.ready  = 1'b0;
        @(negedge clk);
        bus.start  = 1'b0;
        // Scramble the inputs: the stream must come from the latched copy.
        bus.digits = $urandom;
        bus.ops    = 7'($urandom);
        bus.nterms = 4'($urandom);
        chk("first_valid", 32'(bus.valid), 32'd1);
        k   = 0;
        cyc = 0;
        while (k < q.size() && cyc < 300) begin
            chk("valid", 32'(bus.valid), 32'd1);
            chk("busy", 32'(bus.busy), 32'd1);
            chk("char", 32'(bus.out), 32'(q[k]));
            chk("done_early", 32'(bus.done), 32'd0);
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = (cyc % 3 == 0);
            else r = 1'($urandom_range(0, 1));
            bus.ready = r;
            bus.start = poke_busy && (cyc == 1);
            @(negedge clk);
            chk("no_err", 32'(bus.err), 32'd0);
            if (r) k++;
            cyc++;
        end
        bus.start = 1'b0;
        if (k < q.size()) chk("stream_timeout", 32'(k), 32'(q.size()));
        chk("done", 32'(bus.done), 32'd1);
        chk("busy_low", 32'(bus.busy), 32'd0);
        chk("valid_low", 32'(bus.valid), 32'd0);
        bus.ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("idle_valid", 32'(bus.valid), 32'd0);
    endtask

    task automatic reject_req(input int n, input logic [4*MT-1:0] d, input string tag);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.nterms = n[NW-1:0];
        bus.digits = d;
        bus.ready  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk(tag, 32'(bus.err), 32'd1);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.err), 32'd0);
        chk({tag, "_idle"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clr        = 1'b1;
        bus.start  = 1'b0;
        bus.nterms = '0;
        bus.digits = '0;
        bus.ops    = '0;
        bus.ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        clr = 1'b0;

        send(3, 32'hFFFF_F321, 7'b000_0010, 0, 1'b0);   // "1+2*3"
        send(1, 32'hABCD_EF07, 7'h7F, 0, 1'b0);          // "7"
        send(3, 32'h0000_0321, 7'b000_0010, 1, 1'b0);   // backpressure
        send(3, 32'h0000_0321, 7'b000_0010, 0, 1'b1);   // start while busy
        send(MT, 32'h9876_5432, 7'b101_0101, 2, 1'b0);  // full length

        reject_req(2, 32'h0000_00A4, "rej_bcd");
        reject_req(0, 32'h0000_0001, "rej_zero");
        reject_req(MT + 1, 32'h0000_0000, "rej_over");

        // Abort after two transfers; clr must clear outputs without a clock edge.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.nterms = 4'd3;
        bus.digits = 32'h0000_0321;
        bus.ops    = 7'b000_0010;
        bus.ready  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_clr_char", 32'(bus.out), 32'h32);
        #1 clr = 1'b1;
        #1;
        chk("clr_valid", 32'(bus.valid), 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_out", 32'(bus.out), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        send(3, 32'h0000_0321, 7'b000_0010, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int               n;
            logic [4*MT-1:0]  d;
            logic [MT-2:0]    o;
            n = $urandom_range(0, MT + 1);
            d = $urandom;
            o = 7'($urandom);
            if ($urandom_range(0, 3) != 0)
                for (int i = 0; i < MT; i++)
                    if (i < n) d[4*i +: 4] = 4'($urandom_range(0, 9));
            if (req_legal(n, d)) send(n, d, o, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else reject_req(n, d, "rej_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_tx.md
# expr_tx

Serial ASCII expression transmitter: takes a batch of decimal operands and operators and streams them one character per accepted transfer as `d (op d)*`, e.g. "1+2*3". It is the producing end of the character stream the expression-recognizer path consumes. A valid/ready handshake paces it, and a one-cycle `done` marks completion.

## Interface
- `MAX_TERMS`, default 8: maximum operand count per expression (≥1).
- `NW`, default $clog2(MAX_TERMS+1): width of `nterms`.

Ports:
- `clk`  in  1: clock, rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request to transmit; sampled only in IDLE.
- `nterms`  in  NW: operand count for this expression.
- `digits`  in  4*MAX_TERMS: BCD operands; operand i is `digits[4i+3:4i]`; operand 0 is sent first.
- `ops`  in  MAX_TERMS-1: operators; bit i sits between operand i and operand i+1; 0 = '+', 1 = '*'.
- `out`  out  8: ASCII character.
- `valid`  out  1: `out` holds a character.
- `ready`  in  1: sink accepts; transfer occurs on a rising edge where `valid && ready`.
- `busy`  out  1: an expression is in flight.
- `done`  out  1: one-cycle pulse after the last character is transferred.
- `err`  out  1: one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, DIGIT, OP.
- **IDLE, `start`=1:** validate the request.
  - Invalid if `nterms`==0, or `nterms`>MAX_TERMS, or any operand i<`nterms` is >9.
  - Operands at or beyond `nterms`, and their ops bits, are ignored.
- **Invalid request:** `err`=1 for one cycle, stay IDLE, no character emitted.
- **Valid request:**
  - Latch `digits`, `ops` and `nterms` into internal registers.
  - Clear the index counter `idx`=0.
  - Go to DIGIT with `busy`=1.
- **DIGIT:** `out` = "0"+operand[idx], `valid`=1.
  - On transfer, if idx==nterms-1: go to IDLE, `valid`=0, `busy`=0, `done`=1 for one cycle.
  - On transfer, otherwise: go to OP.
- **OP:** `out` = ops[idx] ? "*" : "+", `valid`=1.
  - On transfer: idx←idx+1, go to DIGIT.
- Total characters per expression: 2·nterms−1.
- Inputs are latched at start, so later changes to `digits`, `ops` or `nterms` do not affect the stream in flight.
- `start` while `busy` is ignored: no `err`, no restart.

## Timing
- Reset values: `out`=8'h00, `valid`=0, `busy`=0, `done`=0, `err`=0; state IDLE; idx=0.
- All outputs are registered.
- `clr` clears everything immediately, without waiting for a clock edge, including mid-stream; the partial expression is abandoned.
- Latency: `start` sampled at edge N gives the first character with `valid`=1 after edge N. With `ready` held high, one character transfers per cycle.
- Backpressure: while `valid && !ready`, `out` and `valid` hold stable. `valid` never drops without a transfer, except on `clr`.
- `done`, `busy` falling and `valid` falling all occur together, on the cycle after the final transfer edge.
- The earliest new `start` is sampled on the edge after `done` is asserted, giving no idle gap beyond that one cycle.
- `ready` is ignored while `valid`=0.

## Structure
- Shared package `expr_pkg` holds:
  - ASCII constants `CH_ZERO`="0", `CH_ADD`="+", `CH_MUL`="*".
  - Operator encoding `OP_ADD`=0, `OP_MUL`=1.
  - The state enum (IDLE/DIGIT/OP). The recognizer side uses the same constants.
- One sub-module is natural: `expr_req_check`, a combinational validator taking `nterms` and `digits` and returning `ok`. It keeps the range and BCD check out of the FSM.
- Everything else (latch registers, idx counter, FSM, output mux) lives in `expr_tx`.

## Test plan
- **Basic stream:** `nterms`=3, digits 1,2,3, ops = {*,+} (bit0='+', bit1='*'), `ready`=1 → "1","+","2","*","3" on 5 consecutive cycles, then `done` for one cycle and `busy`=0.
- **Single term:** `nterms`=1, operand 7 → single "7" (8'h37), then `done`. No operator emitted; `ops` is ignored.
- **Backpressure:** same stream as the basic case with `ready` toggling 1,0,0,1,… → each character holds stable while `ready`=0. Stream content is unchanged, and `done` comes only after the 5th transfer.
- **Reject:**
  - `nterms`=2 with operand1=4'hA → `err` pulse, `valid` stays 0, state stays IDLE.
  - `nterms`=0 → `err`.
  - `nterms`=MAX_TERMS+1 → `err`.
- **Reset mid-stream:** assert `clr` after the 2nd transfer → `valid`, `busy` and `out` drop to 0 immediately. The next `start` re-emits from the first character.
- **Start while busy:** pulse `start` with different `digits` mid-stream → no `err`, and the current stream completes with its originally latched values.
